// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM state encodings,
// the default data-segment base address and the RAM word-index width helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  localparam logic [31:0] DEFAULT_DATA_BASE = 32'h1001_0000;

  // Number of bits needed to index a RAM of depth_words 32-bit words.
  function automatic int idx_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide synchronous single-port RAM. One write enable and one read
// enable share the address; the read result is registered and held until
// the next read. A write cycle leaves the read register untouched.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Store on a write, otherwise capture the addressed word on a read.
  // NOTE: the storage and read register have no reset; clearing a RAM is not
  // something hardware can do in one edge, and contents must survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller sitting behind the multicycle core. Accepts one
// load/store in IDLE, waits LATENCY-1 extra edges in WAIT, commits the access
// to dmem_array and strobes ready for one RESP cycle. Out-of-window accesses
// read 0 and drop writes.
// Optional feature: define DMEM_FAULT_CHECK_EN to reject misaligned and
// dual (MemRead+MemWrite) requests and pulse err alongside ready on any fault.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int             AW        = idx_width(DEPTH_WORDS);
  localparam int             CW        = $clog2(LATENCY + 1);
  localparam bit             SINGLE    = (LATENCY == 1);
  localparam logic [31:0]    SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [CW-1:0]  CNT_START = CW'(LATENCY - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [31:0]     addr_q, data_q;
  logic            wr_q;
  logic            rd_zero_q;

  logic            accept, commit;
  logic [31:0]     c_addr, c_data, offset;
  logic            c_wr, in_range, acc_ok;
  logic [AW-1:0]   index;
  logic            ram_we, ram_re;
  logic [31:0]     ram_rdata;

  assign accept = (state == S_IDLE) && (MemRead || MemWrite);
  // A single-cycle build commits on the accept edge itself, so the access
  // fields come straight from the core in IDLE and from the latches later.
  assign commit = (accept && SINGLE) || ((state == S_WAIT) && (cnt == CNT_ONE));
  assign c_addr = (state == S_IDLE) ? dAddress   : addr_q;
  assign c_data = (state == S_IDLE) ? dWriteData : data_q;
  assign c_wr   = (state == S_IDLE) ? MemWrite   : wr_q;

  assign offset   = c_addr - DATA_BASE;
  assign in_range = offset < SPAN;
  assign index    = offset[AW+1:2];

`ifdef DMEM_FAULT_CHECK_EN
  logic dual_q, fault_q;
  logic c_dual, misal;
  assign c_dual = (state == S_IDLE) ? (MemRead && MemWrite) : dual_q;
  assign misal  = |offset[1:0];
  // A dual request that is otherwise clean still writes; only err reports it.
  assign acc_ok = in_range && !misal;

  // Remember the dual flag at accept and the fault verdict at commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dual_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (accept) dual_q <= MemRead && MemWrite;
      if (commit) fault_q <= !in_range || misal || c_dual;
    end
  end
`else
  // Misaligned addresses simply drop their low bits.
  assign acc_ok = in_range;
`endif

  assign ram_we = commit && c_wr && acc_ok;
  assign ram_re = commit && !c_wr && acc_ok;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (index),
    .wdata(c_data),
    .rdata(ram_rdata)
  );

  // State register, wait counter, request latches and the read-zero flag.
  // NOTE: every flop here uses <= so all of them see pre-edge values and the
  // block order cannot change behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= dAddress;
        data_q <= dWriteData;
        wr_q   <= MemWrite;
        if (!SINGLE) cnt <= CNT_START;
      end else if (state == S_WAIT) begin
        cnt <= cnt - CNT_ONE;
      end
      // A load that misses the window (or faults) presents 0 until the next load.
      if (commit && !c_wr) rd_zero_q <= !acc_ok;
    end
  end

  // Next-state decode: requests are only looked at in IDLE.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = SINGLE ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == CNT_ONE) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: strobes from the state, held load data from the RAM register.
  always_comb begin
    ready     = (state == S_RESP);
    busy      = (state != S_IDLE);
    dReadData = rd_zero_q ? 32'h0 : ram_rdata;
`ifdef DMEM_FAULT_CHECK_EN
    err       = (state == S_RESP) && fault_q;
`else
    err       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (LATENCY 1, 3, 4) share a clock.
// A transaction-level model tracks, per instance, the accept edge of the
// in-flight request, a word array of RAM contents and the last load value;
// a negedge process compares every output against it each cycle.
module tb_data_mem_ctrl;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          LAT [3] = '{1, 3, 4};
`ifdef DMEM_FAULT_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic        clk;
  logic        rst_n [3];
  logic        mr    [3];
  logic        mw    [3];
  logic [31:0] addr  [3];
  logic [31:0] wd    [3];
  logic [31:0] rdd   [3];
  logic        rdy   [3];
  logic        bsy   [3];
  logic        er    [3];

  data_mem_ctrl #(.DATA_BASE(BASE), .DEPTH_WORDS(1024), .LATENCY(LAT[0])) u_l1 (
    .clk(clk), .rst(rst_n[0]), .MemRead(mr[0]), .MemWrite(mw[0]), .dAddress(addr[0]),
    .dWriteData(wd[0]), .dReadData(rdd[0]), .ready(rdy[0]), .busy(bsy[0]), .err(er[0]));
  data_mem_ctrl #(.DATA_BASE(BASE), .DEPTH_WORDS(1024), .LATENCY(LAT[1])) u_l3 (
    .clk(clk), .rst(rst_n[1]), .MemRead(mr[1]), .MemWrite(mw[1]), .dAddress(addr[1]),
    .dWriteData(wd[1]), .dReadData(rdd[1]), .ready(rdy[1]), .busy(bsy[1]), .err(er[1]));
  data_mem_ctrl #(.DATA_BASE(BASE), .DEPTH_WORDS(1024), .LATENCY(LAT[2])) u_l4 (
    .clk(clk), .rst(rst_n[2]), .MemRead(mr[2]), .MemWrite(mw[2]), .dAddress(addr[2]),
    .dWriteData(wd[2]), .dReadData(rdd[2]), .ready(rdy[2]), .busy(bsy[2]), .err(er[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          m_active   [3];
  int          m_acc      [3];
  logic [31:0] m_a        [3];
  logic [31:0] m_d        [3];
  bit          m_wr       [3];
  bit          m_dual     [3];
  bit          m_fault    [3];
  logic [31:0] m_rd       [3];
  bit          m_rd_known [3];
  logic [31:0] mm [3][1024];
  bit          mk [3][1024];

  task automatic model_reset(input int k);
    m_active[k]   = 1'b0;
    m_rd[k]       = 32'h0;
    m_rd_known[k] = 1'b1;
    m_fault[k]    = 1'b0;
  endtask

  task automatic model_commit(input int k);
    logic [31:0] off;
    bit inr, mis, ok;
    int idx;
    off = m_a[k] - BASE;
    inr = off < 32'd4096;
    mis = off[1:0] != 2'b00;
    ok  = inr && !(FC && mis);
    idx = int'(off[11:2]);
    m_fault[k] = FC && (!inr || mis || m_dual[k]);
    if (m_wr[k]) begin
      if (ok) begin
        mm[k][idx] = m_d[k];
        mk[k][idx] = 1'b1;
      end
    end else if (ok) begin
      m_rd[k]       = mm[k][idx];
      m_rd_known[k] = mk[k][idx];
    end else begin
      m_rd[k]       = 32'h0;
      m_rd_known[k] = 1'b1;
    end
  endtask

  // Per edge: an in-flight request commits LAT-1 edges after accept and is
  // retired LAT edges after accept; an idle instance accepts any request.
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n[k]) begin
        model_reset(k);
      end else if (m_active[k]) begin
        if (cyc - m_acc[k] == LAT[k] - 1) model_commit(k);
        else if (cyc - m_acc[k] == LAT[k]) m_active[k] = 1'b0;
      end else if (mr[k] || mw[k]) begin
        m_active[k] = 1'b1;
        m_acc[k]    = cyc;
        m_a[k]      = addr[k];
        m_d[k]      = wd[k];
        m_wr[k]     = mw[k];
        m_dual[k]   = mr[k] && mw[k];
        if (LAT[k] == 1) model_commit(k);
      end
    end
  end

  // Compare every output of every instance against the model each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        bit exp_ready;
        exp_ready = m_active[k] && (cyc - m_acc[k] == LAT[k] - 1);
        check($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(m_active[k]));
        check($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(exp_ready));
        check($sformatf("err[%0d]", k), 32'(er[k]), 32'(exp_ready && m_fault[k]));
        if (m_rd_known[k]) check($sformatf("dReadData[%0d]", k), rdd[k], m_rd[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    mr[k] = rd; mw[k] = wr; addr[k] = a; wd[k] = d;
    tick();
    mr[k] = 1'b0; mw[k] = 1'b0;
  endtask

  // Run out the in-flight request, optionally poking stray requests that
  // the controller must ignore while busy.
  task automatic finish_op(input int k, input bit stray);
    int n = 0;
    while (m_active[k] && n < 20) begin
      if (stray && $urandom_range(0, 2) == 0) begin
        mr[k] = 1'b1;
        mw[k] = 1'($urandom_range(0, 1));
        addr[k] = BASE + 32'($urandom_range(0, 15)) * 4;
      end
      tick();
      mr[k] = 1'b0; mw[k] = 1'b0;
      n++;
    end
    if (m_active[k]) check($sformatf("timeout[%0d]", k), 32'd1, 32'd0);
  endtask

  task automatic op(input int k, input bit rd, input bit wr,
                    input logic [31:0] a, input logic [31:0] d);
    issue(k, rd, wr, a, d);
    finish_op(k, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ready_cnt, busy_cnt, ready_pos;
    logic [31:0] a;
    int sel;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b1; mr[k] = 1'b0; mw[k] = 1'b0; addr[k] = '0; wd[k] = '0;
      model_reset(k);
      for (int w = 0; w < 1024; w++) mk[k][w] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset busy", 32'(bsy[0]), 32'd0);
    check("reset ready", 32'(rdy[0]), 32'd0);
    check("reset dReadData", rdd[0], 32'h0);
    tick(); tick();
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    tick();

    // Store then load back with LATENCY=1.
    issue(0, 1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF);
    check("st ready", 32'(rdy[0]), 32'd1);
    check("st busy", 32'(bsy[0]), 32'd1);
    tick();
    check("st ready end", 32'(rdy[0]), 32'd0);
    check("st busy end", 32'(bsy[0]), 32'd0);
    issue(0, 1'b1, 1'b0, 32'h1001_0008, 32'h0);
    check("ld ready", 32'(rdy[0]), 32'd1);
    check("ld data", rdd[0], 32'hDEAD_BEEF);
    finish_op(0, 1'b0);
    op(0, 1'b0, 1'b1, 32'h1001_000C, 32'h1111_1111);
    check("ld data held", rdd[0], 32'hDEAD_BEEF);

    // LATENCY=3 load with a stray MemRead during WAIT.
    op(1, 1'b0, 1'b1, 32'h1001_0014, 32'hCAFE_F00D);
    issue(1, 1'b1, 1'b0, 32'h1001_0014, 32'h0);
    ready_cnt = 0; busy_cnt = 0; ready_pos = 0;
    for (int c = 1; c <= 6; c++) begin
      if (rdy[1]) begin ready_cnt++; ready_pos = c; end
      if (bsy[1]) busy_cnt++;
      mr[1] = (c == 1);
      tick();
      mr[1] = 1'b0;
    end
    check("lat3 busy cycles", 32'(busy_cnt), 32'd3);
    check("lat3 ready count", 32'(ready_cnt), 32'd1);
    check("lat3 ready cycle", 32'(ready_pos), 32'd3);
    check("lat3 data", rdd[1], 32'hCAFE_F00D);

    // Out-of-range store and load; word 0 must stay intact.
    op(0, 1'b0, 1'b1, 32'h1001_0000, 32'hA5A5_A5A5);
    issue(0, 1'b0, 1'b1, 32'h1001_1000, 32'h1234_5678);
    check("oor st err", 32'(er[0]), 32'(FC));
    finish_op(0, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h1001_1000, 32'h0);
    check("oor ld err", 32'(er[0]), 32'(FC));
    check("oor ld data", rdd[0], 32'h0);
    finish_op(0, 1'b0);
    op(0, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
    check("word0 intact", rdd[0], 32'hA5A5_A5A5);

    // Misaligned store to 0x1001000A.
    issue(0, 1'b0, 1'b1, 32'h1001_000A, 32'h0BAD_F00D);
    check("misal err", 32'(er[0]), 32'(FC));
    finish_op(0, 1'b0);
    op(0, 1'b1, 1'b0, 32'h1001_0008, 32'h0);
    check("misal word2", rdd[0], FC ? 32'hDEAD_BEEF : 32'h0BAD_F00D);

    // Reset during WAIT of a LATENCY=4 store.
    op(2, 1'b0, 1'b1, 32'h1001_001C, 32'h7777_7777);
    op(2, 1'b1, 1'b0, 32'h1001_001C, 32'h0);
    check("lat4 ld", rdd[2], 32'h7777_7777);
    issue(2, 1'b0, 1'b1, 32'h1001_001C, 32'h9999_9999);
    tick();
    rst_n[2] = 1'b0;
    model_reset(2);
    #1;
    check("midrst busy", 32'(bsy[2]), 32'd0);
    check("midrst ready", 32'(rdy[2]), 32'd0);
    check("midrst data", rdd[2], 32'h0);
    tick(); tick(); tick(); tick();
    rst_n[2] = 1'b1;
    tick();
    op(2, 1'b1, 1'b0, 32'h1001_001C, 32'h0);
    check("midrst word kept", rdd[2], 32'h7777_7777);

    // Randomized traffic per instance over a 16-word window plus faults.
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 16; w++) op(k, 1'b0, 1'b1, BASE + 32'(w) * 4, $urandom);
      for (int t = 0; t < 120; t++) begin
        case ($urandom_range(0, 9))
          0: a = BASE + 32'h1000 + 32'($urandom_range(0, 255)) * 4;
          1: a = BASE - 32'($urandom_range(1, 64)) * 4;
          2: a = BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
          default: a = BASE + 32'($urandom_range(0, 15)) * 4;
        endcase
        sel = int'($urandom_range(0, 5));
        issue(k, sel <= 2 || sel == 5, sel >= 3, a, $urandom);
        finish_op(k, 1'b1);
        for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
      end
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory controller directly downstream of the multicycle core.
- Consumes the core's MemRead, MemWrite, dAddress and dWriteData; returns dReadData, which the core selects as write-back data for loads.
- Holds a word-addressed data RAM behind a small FSM with configurable access latency, an address-window check and a completion strobe, so a later stall-capable core can wait on it.

Parameters:
- DATA_BASE, 32'h10010000: byte address of word 0 of the data RAM.
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; must be a power of two, at least 2.
- LATENCY, 1: clock edges from request accept to operation commit; at least 1. The value 1 matches the current core, whose MEM state is followed by WB.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- MemRead  in  1  load request, level, sampled in IDLE.
- MemWrite  in  1  store request, level, sampled in IDLE.
- dAddress  in  32  byte address.
- dWriteData  in  32  store data.
- dReadData  out  32  load result; registered and held.
- ready  out  1  one-cycle completion strobe.
- busy  out  1  high while a request is in flight (WAIT or RESP).
- err  out  1  access fault strobe; present only under the optional feature.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, counter=0, dReadData=0, ready=0, busy=0, err=0. RAM contents are not cleared. A reset mid-operation drops the pending access and no write commits.
- Offset = dAddress - DATA_BASE (32-bit, wraps). The access is in range iff offset < 4*DEPTH_WORDS. Word index = offset[log2(DEPTH_WORDS)+1:2].
- States:
  - IDLE: accept on an edge where MemRead or MemWrite is high. Latch address, data and op.
    - If both are high, treat as a write and ignore the read.
    - LATENCY=1: the access commits on the accept edge; next state RESP.
    - Otherwise: counter=LATENCY-1; next state WAIT.
  - WAIT: counter decrements each edge. On the edge where counter==1, the access commits and the next state is RESP.
  - RESP: ready=1 for exactly one cycle; next state IDLE unconditionally. Requests seen in RESP or WAIT are ignored.
- Commit:
  - Read: dReadData <= RAM[index] when in range, else 0.
  - Write: RAM[index] <= latched data when in range, else suppressed. dReadData is unchanged by writes.
- dReadData holds its value until the next read commits.
- busy = (state != IDLE).
- With the current core (LATENCY=1), load data is valid throughout the core's WB cycle.
- Misaligned address (offset[1:0] != 0): the low bits are ignored and the access is aligned down, unless the optional feature is enabled.

Optional Feature:
- Macro DMEM_FAULT_CHECK_EN.
- Defined:
  - err pulses high alongside ready when an access is out of range, misaligned, or has MemRead and MemWrite both high.
  - A faulting read returns 0 and a faulting write is suppressed.
  - Exception: a dual-request that is in range and aligned still writes.
- Undefined:
  - No err port logic; err is tied 0.
  - Misaligned accesses align down.
  - Out-of-range accesses still read 0 and suppress writes.

Decomposition:
- Shared package (dmem_pkg): FSM state encodings (IDLE=2'b00, WAIT=2'b01, RESP=2'b10), the default DATA_BASE, and the word-index width function (clog2 of DEPTH_WORDS).
- One sub-module, dmem_array: synchronous single-port RAM with one write-enable and a registered read, no reset. The controller owns the FSM, latching and range logic.

Test Plan:
- Reset, then store with LATENCY=1: rst low then high; MemWrite=1 for one cycle, dAddress=32'h10010008, dWriteData=32'hDEADBEEF -> ready pulses the next cycle, busy high for that one cycle, RAM word 2 = DEADBEEF.
- Load back: MemRead=1, dAddress=32'h10010008 -> dReadData=32'hDEADBEEF with ready in the next cycle; the value is held after later writes to other words.
- LATENCY=3: load issued -> busy for 3 cycles, ready on the 3rd cycle after accept; a second MemRead pulse during WAIT is ignored (no extra ready).
- Out of range: store 32'h12345678 at 32'h10011000 (DEPTH_WORDS=1024), then load the same address -> dReadData=0; RAM word 0 is unchanged. With DMEM_FAULT_CHECK_EN, err pulses on both accesses.
- Misaligned 32'h1001000A:
  - Without the feature: the store lands in word 2.
  - With the feature: err=1 and word 2 is unchanged.
- Reset mid-operation (LATENCY=4): assert rst low during WAIT of a store -> IDLE, busy=0, no ready, target word unchanged; dReadData=0.
